// File: rtl/tff_counter_if.sv
// Control/status bundle for tff_counter.
// Master drives the controls; slave is the counter.
interface tff_counter_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] mod_val;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             q;
    logic             done;

    modport master (
        output en, mode, mod_val, load, load_val,
        input  count, tc, q, done
    );

    modport slave (
        input  en, mode, mod_val, load, load_val,
        output count, tc, q, done
    );
endinterface

// File: rtl/tff_counter.sv
// Toggle counter with up/down/modulo/one-shot modes, tc pulse and toggle q.
// Optional en-qualified prescaler enabled by TFF_COUNTER_PRESCALE_EN.
module tff_counter #(
    parameter int WIDTH   = 8,
    parameter int PRE_DIV = 4
) (
    input logic          clk,
    input logic          reset,
    tff_counter_if.slave ctr_io
);
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             q_q, q_d;
    logic             step;
    logic             wrap;

`ifdef TFF_COUNTER_PRESCALE_EN
    localparam int PW = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
    logic [PW-1:0] pre_q, pre_d;
    logic          pre_last;

    // PRE_DIV=1 keeps pre_q at 0, so every enabled edge steps
    assign pre_last = (pre_q == PW'(PRE_DIV - 1));
    assign step     = ctr_io.en & pre_last;

    always_comb begin
        pre_d = pre_q;
        if (ctr_io.load) begin
            pre_d = '0;
        end else if (ctr_io.en) begin
            pre_d = pre_last ? '0 : pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    assign step = ctr_io.en;
`endif

    always_comb begin
        count_d = count_q;
        wrap    = 1'b0;
        if (ctr_io.load) begin
            count_d = ctr_io.load_val;
        end else if (step) begin
            unique case (ctr_io.mode)
                2'b00: begin
                    count_d = count_q + WIDTH'(1);
                    wrap    = &count_q;
                end
                2'b01: begin
                    if (count_q >= ctr_io.mod_val) begin
                        count_d = '0;
                        wrap    = 1'b1;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end
                2'b10: begin
                    if (count_q == '0) begin
                        count_d = ctr_io.mod_val;
                        wrap    = 1'b1;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
                2'b11: begin
                    // Zero is sticky until the next load
                    if (count_q > WIDTH'(1)) begin
                        count_d = count_q - WIDTH'(1);
                    end else if (count_q == WIDTH'(1)) begin
                        count_d = '0;
                        wrap    = 1'b1;
                    end
                end
                default: count_d = count_q;
            endcase
        end
        tc_d = wrap;
        q_d  = q_q ^ wrap;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            q_q     <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            q_q     <= q_d;
        end
    end

    assign ctr_io.count = count_q;
    assign ctr_io.tc    = tc_q;
    assign ctr_io.q     = q_q;
    assign ctr_io.done  = (ctr_io.mode == 2'b11) && (count_q == '0);
endmodule

// File: tb/tb_tff_counter.sv
// Self-checking bench for tff_counter: arithmetic reference model plus
// directed scenarios with hand-computed expectations.
module tb_tff_counter;
    localparam int W    = 4;
    localparam int P    = 4;
    localparam int MAXV = (1 << W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    tff_counter_if #(.WIDTH(W)) bus ();

    tff_counter #(
        .WIDTH  (W),
        .PRE_DIV(P)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ctr_io(bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    int   m_cnt = 0;
    logic m_tc  = 1'b0;
    logic m_q   = 1'b0;
    int   m_pre = 0;

    always @(posedge clk or posedge reset) begin
        int   c;
        int   p;
        logic w;
        logic s;
        if (reset) begin
            m_cnt <= 0;
            m_tc  <= 1'b0;
            m_q   <= 1'b0;
            m_pre <= 0;
        end else begin
            c = m_cnt;
            p = m_pre;
            w = 1'b0;
            s = bus.en;
`ifdef TFF_COUNTER_PRESCALE_EN
            s = bus.en && (m_pre == P - 1);
            if (bus.load) p = 0;
            else if (bus.en) p = (m_pre + 1) % P;
`endif
            if (bus.load) begin
                c = int'(bus.load_val);
            end else if (s) begin
                case (bus.mode)
                    2'd0: begin
                        w = (c == MAXV);
                        c = (c + 1) % (MAXV + 1);
                    end
                    2'd1: begin
                        if (c >= int'(bus.mod_val)) begin
                            c = 0;
                            w = 1'b1;
                        end else c = c + 1;
                    end
                    2'd2: begin
                        if (c == 0) begin
                            c = int'(bus.mod_val);
                            w = 1'b1;
                        end else c = c - 1;
                    end
                    default: begin
                        if (c == 1) begin
                            c = 0;
                            w = 1'b1;
                        end else if (c > 1) c = c - 1;
                    end
                endcase
            end
            m_cnt <= c;
            m_pre <= p;
            m_tc  <= w;
            m_q   <= m_q ^ w;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("cmp_count", 32'(bus.count), 32'(m_cnt));
        chk("cmp_tc", 32'(bus.tc), 32'(m_tc));
        chk("cmp_q", 32'(bus.q), 32'(m_q));
        chk("cmp_done", 32'(bus.done),
            32'((bus.mode == 2'b11) && (m_cnt == 0)));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.en       = 1'b0;
        bus.mode     = 2'b11;
        bus.mod_val  = '0;
        bus.load     = 1'b0;
        bus.load_val = '0;
        #1 reset = 1'b1;
        tick();
        tick();
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_tc", 32'(bus.tc), 0);
        chk("rst_q", 32'(bus.q), 0);
        chk("rst_done", 32'(bus.done), 1);
        bus.mode = 2'b00;
        reset    = 1'b0;
        bus.en   = 1'b1;
`ifndef TFF_COUNTER_PRESCALE_EN
        // Free-run wrap
        repeat (16) tick();
        chk("t1_cnt16", 32'(bus.count), 0);
        chk("t1_tc16", 32'(bus.tc), 1);
        tick();
        chk("t1_cnt17", 32'(bus.count), 1);
        chk("t1_q", 32'(bus.q), 1);
        chk("t1_tc17", 32'(bus.tc), 0);
        // Modulo up
        bus.load = 1'b1; bus.load_val = 0;
        bus.mode = 2'b01; bus.mod_val = 5;
        tick();
        chk("t2_load", 32'(bus.count), 0);
        bus.load = 1'b0;
        repeat (5) tick();
        chk("t2_cnt5", 32'(bus.count), 5);
        chk("t2_tc5", 32'(bus.tc), 0);
        tick();
        chk("t2_wrap", 32'(bus.count), 0);
        chk("t2_wtc", 32'(bus.tc), 1);
        chk("t2_wq", 32'(bus.q), 0);
        bus.mod_val = 0;
        tick();
        chk("t2_m0_tc", 32'(bus.tc), 1);
        chk("t2_m0_q1", 32'(bus.q), 1);
        tick();
        chk("t2_m0_q2", 32'(bus.q), 0);
        // Count above mod_val wraps on next step
        bus.load = 1'b1; bus.load_val = 10;
        tick();
        bus.load = 1'b0; bus.mod_val = 5;
        tick();
        chk("t2_above", 32'(bus.count), 0);
        chk("t2_above_tc", 32'(bus.tc), 1);
        // One-shot down
        bus.mode = 2'b11; bus.load = 1'b1;
        bus.load_val = 3; bus.en = 1'b0;
        tick();
        chk("t3_load", 32'(bus.count), 3);
        chk("t3_done0", 32'(bus.done), 0);
        bus.load = 1'b0; bus.en = 1'b1;
        repeat (3) tick();
        chk("t3_zero", 32'(bus.count), 0);
        chk("t3_tc", 32'(bus.tc), 1);
        chk("t3_done", 32'(bus.done), 1);
        tick();
        chk("t3_hold", 32'(bus.count), 0);
        chk("t3_notc", 32'(bus.tc), 0);
        bus.load = 1'b1;
        tick();
        chk("t3_reload", 32'(bus.count), 3);
        chk("t3_rl_tc", 32'(bus.tc), 0);
        // Modulo down, load beats step
        bus.mode = 2'b10; bus.mod_val = 2; bus.load_val = 7;
        tick();
        chk("t4_load", 32'(bus.count), 7);
        chk("t4_ltc", 32'(bus.tc), 0);
        bus.load = 1'b0;
        repeat (7) tick();
        chk("t4_zero", 32'(bus.count), 0);
        tick();
        chk("t4_wrap", 32'(bus.count), 2);
        chk("t4_wtc", 32'(bus.tc), 1);
        repeat (3) tick();
        chk("t4_wrap2", 32'(bus.count), 2);
        chk("t4_wtc2", 32'(bus.tc), 1);
        // Async reset mid-count, then gated enable
        bus.mode = 2'b00; bus.load = 1'b1; bus.load_val = 5;
        tick();
        bus.load = 1'b0;
        repeat (4) tick();
        chk("t5_pre", 32'(bus.count), 9);
        #2 reset = 1'b1;
        #1;
        chk("t5_rcnt", 32'(bus.count), 0);
        chk("t5_rq", 32'(bus.q), 0);
        chk("t5_rtc", 32'(bus.tc), 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.en = (i % 2 == 0);
            tick();
        end
        chk("t5_gated", 32'(bus.count), 3);
`else
        repeat (4) tick();
        chk("t6_cnt1", 32'(bus.count), 1);
        repeat (4) tick();
        chk("t6_cnt2", 32'(bus.count), 2);
        repeat (2) tick();
        bus.en = 1'b0;
        repeat (2) tick();
        bus.en = 1'b1;
        tick();
        chk("t6_delay", 32'(bus.count), 2);
        tick();
        chk("t6_step", 32'(bus.count), 3);
`endif
        tick();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
